// File: rtl/lsu_data_mem.sv
// rtl/lsu_data_mem.sv - RV32 load/store unit with byte-addressable synchronous-read data memory
// One request in flight; store/error respond after 1 cycle, loads after 2.
module lsu_data_mem #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 16,
   parameter int DEPTH_WORDS = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [2:0]            req_funct3,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] ReadData,
   output logic                  resp_err
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

   state_t                r_state;
   state_t                w_next;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [1:0]            r_off;
   logic [2:0]            r_f3;

   logic                  w_accept;
   logic                  w_misalign;
   logic                  w_illegal;
   logic                  w_err;
   logic [3:0]            w_be;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic [IDX_W-1:0]      w_idx;
   logic [DATA_WIDTH-1:0] w_shift;
   logic [DATA_WIDTH-1:0] w_ext;
   logic                  w_unused;

   // Upper address bits alias onto the same words; they are deliberately ignored.
   assign w_unused   = &{1'b0, req_addr};
   assign w_idx      = req_addr[2 +: IDX_W];
   assign w_accept   = req_valid && (r_state == IDLE) && !rst;
   assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
   assign w_illegal  = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                       (req_funct3 == 3'b111) || (req_we && req_funct3[2]);
   assign w_err      = w_misalign || w_illegal;
   assign w_wdata    = req_wdata << {req_addr[1:0], 3'b000};

   always_comb begin
      w_be = 4'b0000;
      case (req_funct3[1:0])
         2'b00:   w_be = 4'b0001 << req_addr[1:0];
         2'b01:   w_be = req_addr[1] ? 4'b1100 : 4'b0011;
         default: w_be = 4'b1111;
      endcase
   end

   // Memory array has no reset; stores commit on the accepting edge itself.
   always_ff @(posedge clk) begin
      if (w_accept && req_we && !w_err) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
         end
      end
      if (w_accept && !req_we && !w_err) r_rdata <= r_mem[w_idx];
   end

   assign w_shift = r_rdata >> {r_off, 3'b000};

   always_comb begin
      w_ext = w_shift;
      case (r_f3)
         3'b000:  w_ext = {{24{w_shift[7]}}, w_shift[7:0]};
         3'b001:  w_ext = {{16{w_shift[15]}}, w_shift[15:0]};
         3'b100:  w_ext = {24'b0, w_shift[7:0]};
         3'b101:  w_ext = {16'b0, w_shift[15:0]};
         default: w_ext = w_shift;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      case (r_state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) w_next = (w_err || req_we) ? RESP : RD_WAIT;
         end
         RD_WAIT: w_next = RESP;
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_off    <= 2'b00;
         r_f3     <= 3'b000;
         ReadData <= '0;
         resp_err <= 1'b0;
      end else if (w_accept) begin
         r_off    <= req_addr[1:0];
         r_f3     <= req_funct3;
         ReadData <= '0;
         resp_err <= w_err;
      end else if (r_state == RD_WAIT) begin
         ReadData <= w_ext;
      end
   end

endmodule

// File: tb/tb_lsu_data_mem.sv
// tb/tb_lsu_data_mem.sv - self-checking bench for lsu_data_mem
// Directed vector table, hand sequences for backpressure/reset, then random traffic vs. a byte-array model.
module tb_lsu_data_mem;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [15:0] req_addr;
   logic [2:0]  req_funct3;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] ReadData;
   logic        resp_err;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] mdl [0:4095];

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [2:0]  f3;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   vec_t vecs[$];

   lsu_data_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH_WORDS(1024)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_funct3 (req_funct3),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .ReadData   (ReadData),
      .resp_err   (resp_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic add(input logic we, input logic [15:0] addr, input logic [2:0] f3,
                      input logic [31:0] wdata, input logic [31:0] rd, input logic err, input int lat);
      vec_t v;
      v.we = we; v.addr = addr; v.f3 = f3; v.wdata = wdata;
      v.exp_rd = rd; v.exp_err = err; v.exp_lat = lat;
      vecs.push_back(v);
   endtask

   // Full transaction: present, accept, count cycles to resp_valid, consume.
   task automatic xact(input logic we, input logic [15:0] addr, input logic [2:0] f3,
                       input logic [31:0] wdata, output logic [31:0] rd, output logic err,
                       output int lat);
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_funct3 = f3; req_wdata = wdata;
      resp_ready = 1'b0;
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      req_wdata = $urandom;
      lat = 1;
      while (!resp_valid && lat < 10) begin @(negedge clk); lat++; end
      rd  = ReadData;
      err = resp_err;
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
   endtask

   function automatic void model(input logic we, input logic [15:0] addr, input logic [2:0] f3,
                                 input logic [31:0] wdata, output logic [31:0] rd,
                                 output logic err, output int lat);
      int a, size;
      longint v;
      a    = int'(addr) % 4096;
      size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      err  = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3 >= 3'd4) || (a % size != 0);
      rd   = 32'h0;
      lat  = (err || we) ? 1 : 2;
      if (err) return;
      if (we) begin
         for (int i = 0; i < size; i++) mdl[a + i] = 8'((wdata >> (8 * i)) & 32'hFF);
      end else begin
         v = 0;
         for (int i = 0; i < size; i++) v = v + longint'(mdl[a + i]) * (longint'(1) << (8 * i));
         if (f3 < 3'd4 && size < 4 && v >= (longint'(1) << (8 * size - 1)))
            v = v - (longint'(1) << (8 * size));
         rd = 32'(v);
      end
   endfunction

   initial begin
      logic [31:0] rd, exp_rd;
      logic        err, exp_err;
      int          lat, exp_lat, t;
      logic        seen;

      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_funct3 = '0;
      req_wdata = '0; resp_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset resp_valid", 32'(resp_valid), 32'd0);
      chk("reset ReadData", ReadData, 32'd0);
      chk("reset resp_err", 32'(resp_err), 32'd0);
      chk("reset req_ready", 32'(req_ready), 32'd1);

      add(1, 16'h0010, 3'b010, 32'hDEADBEEF, 32'h0, 0, 1);
      add(0, 16'h0010, 3'b010, 32'h0,        32'hDEADBEEF, 0, 2);
      add(0, 16'h0011, 3'b000, 32'h0,        32'hFFFFFFBE, 0, 2);
      add(0, 16'h0011, 3'b100, 32'h0,        32'h000000BE, 0, 2);
      add(0, 16'h0012, 3'b001, 32'h0,        32'hFFFFDEAD, 0, 2);
      add(0, 16'h0012, 3'b101, 32'h0,        32'h0000DEAD, 0, 2);
      add(0, 16'h0010, 3'b000, 32'h0,        32'hFFFFFFEF, 0, 2);
      add(1, 16'h0020, 3'b010, 32'h0,        32'h0, 0, 1);
      add(1, 16'h0023, 3'b000, 32'hFFFFFF5A, 32'h0, 0, 1);
      add(1, 16'h0020, 3'b001, 32'hABCD1234, 32'h0, 0, 1);
      add(0, 16'h0020, 3'b010, 32'h0,        32'h5A001234, 0, 2);
      add(1, 16'h0004, 3'b010, 32'hCAFEF00D, 32'h0, 0, 1);
      add(0, 16'h0002, 3'b010, 32'h0,        32'h0, 1, 1);
      add(1, 16'h0005, 3'b001, 32'h0000FFFF, 32'h0, 1, 1);
      add(0, 16'h0010, 3'b011, 32'h0,        32'h0, 1, 1);
      add(1, 16'h0020, 3'b100, 32'hFFFFFFFF, 32'h0, 1, 1);
      add(0, 16'h0004, 3'b010, 32'h0,        32'hCAFEF00D, 0, 2);
      add(0, 16'h0020, 3'b010, 32'h0,        32'h5A001234, 0, 2);
      add(1, 16'h1004, 3'b010, 32'h11111111, 32'h0, 0, 1);
      add(0, 16'h0004, 3'b010, 32'h0,        32'h11111111, 0, 2);

      foreach (vecs[k]) begin
         xact(vecs[k].we, vecs[k].addr, vecs[k].f3, vecs[k].wdata, rd, err, lat);
         chk($sformatf("vec%0d ReadData", k), rd, vecs[k].exp_rd);
         chk($sformatf("vec%0d resp_err", k), 32'(err), 32'(vecs[k].exp_err));
         chk($sformatf("vec%0d latency", k), 32'(lat), 32'(vecs[k].exp_lat));
      end

      // Backpressure: hold the load response for 5 cycles.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0010; req_funct3 = 3'b010;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      t = 0;
      while (!resp_valid && t < 10) begin @(negedge clk); t++; end
      for (int k = 0; k < 5; k++) begin
         chk("bp resp_valid", 32'(resp_valid), 32'd1);
         chk("bp ReadData", ReadData, 32'hDEADBEEF);
         chk("bp resp_err", 32'(resp_err), 32'd0);
         chk("bp req_ready", 32'(req_ready), 32'd0);
         @(negedge clk);
      end
      resp_ready = 1'b1;
      #1 chk("bp req_ready at consume", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1 resp_ready = 1'b0;
      chk("bp req_ready after", 32'(req_ready), 32'd1);

      // Reset while the load is in RD_WAIT.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0010; req_funct3 = 3'b010;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst resp_valid", 32'(resp_valid), 32'd0);
      chk("rst ReadData", ReadData, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      resp_ready = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (resp_valid) seen = 1'b1;
      end
      resp_ready = 1'b0;
      chk("rst no stray response", 32'(seen), 32'd0);
      chk("rst req_ready", 32'(req_ready), 32'd1);
      xact(0, 16'h0010, 3'b010, 32'h0, rd, err, lat);
      chk("post-rst LW", rd, 32'hDEADBEEF);

      // Random traffic in a 16-word window, aliased through random upper address bits.
      for (int w = 0; w < 16; w++) begin
         logic [15:0] a;
         logic [31:0] d;
         a = 16'(w * 4);
         d = $urandom;
         model(1'b1, a, 3'b010, d, exp_rd, exp_err, exp_lat);
         xact(1'b1, a, 3'b010, d, rd, err, lat);
      end
      for (int k = 0; k < 200; k++) begin
         logic        we;
         logic [15:0] a;
         logic [2:0]  f3;
         logic [31:0] d;
         we = 1'($urandom_range(0, 1));
         a  = 16'(($urandom & 32'hF000) | $urandom_range(0, 63));
         f3 = 3'($urandom_range(0, 7));
         d  = $urandom;
         model(we, a, f3, d, exp_rd, exp_err, exp_lat);
         xact(we, a, f3, d, rd, err, lat);
         chk($sformatf("rnd%0d ReadData", k), rd, exp_rd);
         chk($sformatf("rnd%0d resp_err", k), 32'(err), 32'(exp_err));
         chk($sformatf("rnd%0d latency", k), 32'(lat), 32'(exp_lat));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
